// File: rtl/spi_packet_rx.sv
// SPI-slave packet receiver: oversamples sck/cs/mosi in the clk domain, deframes
// HEADER + NUM_CH sample words and hands complete packets to the filter core.
module spi_packet_rx #(
  parameter int unsigned WORD_W      = 14,
  parameter int unsigned NUM_CH      = 2,
  parameter logic [WORD_W-1:0] HEADER = WORD_W'(14'h0FFF),
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          CPOL        = 1'b0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sck,
  input  logic                     cs,
  input  logic                     mosi,
  output logic                     miso,
  input  logic [WORD_W-1:0]        tx_data,
  output logic [NUM_CH*WORD_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err_frame,
  output logic                     err_overrun,
  input  logic                     err_clr
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 2);
  localparam int unsigned CH_W  = $clog2(NUM_CH + 1);
  localparam int unsigned OUT_W = NUM_CH * WORD_W;

  typedef enum logic [1:0] {IDLE, COLLECT, DELIVER} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_d_q, cs_d_q;
  logic [SYNC_STAGES:0]   vld_q;
  logic                   armed_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [WORD_W-1:0]      shift_in_q, tx_shift_q, word_q;
  logic                   word_ok_q, word_bad_q, miso_q;
  state_e                 state_q;
  logic [CH_W-1:0]        ch_cnt_q;
  logic [OUT_W-1:0]       coll_q, out_data_q;
  logic                   out_valid_q, err_frame_q, err_overrun_q;

  logic sck_s, cs_s, mosi_s;
  logic sample_ev, shift_ev, cs_fall_ev, cs_rise_ev, in_win;
  logic frame_set, overrun_set;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sample_ev  = CPOL ? (~sck_s & sck_d_q) : (sck_s & ~sck_d_q);
  assign shift_ev   = CPOL ? (sck_s & ~sck_d_q) : (~sck_s & sck_d_q);
  assign cs_fall_ev = armed_q & cs_d_q & ~cs_s;
  assign cs_rise_ev = armed_q & ~cs_d_q & cs_s;
  assign in_win     = armed_q & ~cs_s;

  assign frame_set   = cs_rise_ev & (bit_cnt_q != CNT_W'(WORD_W));
  assign overrun_set = (state_q == DELIVER) & out_valid_q & ~out_ready;

  // Synchronisers, edge-detect delay flops and arming (vld_q marks real samples)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sck_sync_q  <= {SYNC_STAGES{CPOL}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sck_d_q     <= CPOL;
      cs_d_q      <= 1'b1;
      vld_q       <= '0;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_d_q     <= sck_s;
      cs_d_q      <= cs_s;
      vld_q       <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      if (vld_q[SYNC_STAGES] && cs_s) armed_q <= 1'b1;
    end
  end

  // Word shift-in/out and end-of-window classification
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bit_cnt_q  <= '0;
      shift_in_q <= '0;
      tx_shift_q <= '0;
      miso_q     <= 1'b0;
      word_q     <= '0;
      word_ok_q  <= 1'b0;
      word_bad_q <= 1'b0;
    end else begin
      word_ok_q  <= 1'b0;
      word_bad_q <= 1'b0;
      if (cs_fall_ev) begin
        bit_cnt_q  <= '0;
        shift_in_q <= '0;
        tx_shift_q <= tx_data;
        miso_q     <= tx_data[WORD_W-1];
      end else if (!in_win) begin
        miso_q <= 1'b0;
      end else begin
        if (sample_ev) begin
          shift_in_q <= {shift_in_q[WORD_W-2:0], mosi_s};
          if (bit_cnt_q != CNT_W'(WORD_W + 1)) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
        if (shift_ev) begin
          tx_shift_q <= tx_shift_q << 1;
          miso_q     <= tx_shift_q[WORD_W-2];
        end
      end
      if (cs_rise_ev) begin
        if (bit_cnt_q == CNT_W'(WORD_W)) begin
          word_ok_q <= 1'b1;
          word_q    <= shift_in_q;
        end else begin
          word_bad_q <= 1'b1;
        end
      end
    end
  end

  // Packet deframer and output handshake
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      ch_cnt_q      <= '0;
      coll_q        <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (word_ok_q && word_q == HEADER) begin
            state_q  <= COLLECT;
            ch_cnt_q <= '0;
          end
        end
        COLLECT: begin
          if (word_bad_q) begin
            state_q <= IDLE;
          end else if (word_ok_q) begin
            coll_q[(NUM_CH - 1 - int'(ch_cnt_q)) * WORD_W +: WORD_W] <= word_q;
            if (ch_cnt_q == CH_W'(NUM_CH - 1)) state_q <= DELIVER;
            else                               ch_cnt_q <= ch_cnt_q + CH_W'(1);
          end
        end
        DELIVER: begin
          if (!out_valid_q || out_ready) begin
            out_data_q  <= coll_q;
            out_valid_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      err_frame_q   <= frame_set   | (err_frame_q   & ~err_clr);
      err_overrun_q <= overrun_set | (err_overrun_q & ~err_clr);
    end
  end

  assign miso        = miso_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;

endmodule
